multicycle_datapath: RTL and testbench
======================================

// Module: multicycle_datapath
// PURPOSE
//  Parametrised multi-cycle MIPS-subset core: fetch/decode/execute/mem/writeback FSM over one shared ALU.
//  Owns program ROM, register file and data memory; program loaded via write port while idle.
//  Successor to the single-cycle datapath: configurable width/depths, start/halt control, branch, jump.
// PARAMETERS
//  DATA_W      32  register/ALU/data-memory word width (>=16)
//  REG_COUNT   8   registers (power of 2, 2..32); r0 reads 0, writes ignored
//  IMEM_DEPTH  16  instruction words (power of 2); instructions always 32 bits
//  DMEM_DEPTH  8   data words (power of 2)
// PORTS
//  clk          in   1                  clock, rising edge
//  reset        in   1                  asynchronous, active-low
//  start        in   1                  from IDLE/HALT: pc<=0, begin FETCH
//  prog_we      in   1                  write prog_data to ROM[prog_addr]; honoured only in IDLE/HALT
//  prog_addr    in   $clog2(IMEM_DEPTH) ROM word index
//  prog_data    in   32                 instruction word
//  dbg_addr     in   $clog2(REG_COUNT)  combinational register read select
//  dbg_data     out  DATA_W             RegisterFile[dbg_addr] (0 for r0)
//  pc           out  $clog2(IMEM_DEPTH) current instruction word index
//  busy         out  1                  high in FETCH..WB
//  halted       out  1                  high in HALT
//  err          out  1                  sticky: unknown opcode/funct seen; cleared by start
//  retire       out  1                  1-cycle pulse when an instruction completes
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=0, busy=halted=err=retire=0; registers and DMEM cleared to 0; ROM kept.
//  Fields: op[31:26] rs[25:21] rt[20:16] rd[15:11] sh[10:6] fn[5:0] imm[15:0] tgt[25:0].
//  Register indices use low $clog2(REG_COUNT) bits; imm sign-extended to DATA_W.
//  Opcodes: 000000 R; 100011 lw rt=M[rs+imm]; 101011 sw M[rs+imm]=rt; 000100 beq;
//   001000 addi rt=rs+imm; 000010 j; 111111 halt. Anything else: err=1, go HALT.
//  R funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 0/1),
//   000000 sll rd=rt<<sh; other funct: err=1, HALT, no write.
//  Arithmetic mod 2^DATA_W, overflow ignored. DMEM word address = ALU result mod DMEM_DEPTH.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
//   IDLE/HALT --start--> FETCH (pc=0, err=0); start ignored while busy.
//   FETCH: IR<=ROM[pc]. DECODE: A<=R[rs], B<=R[rt], branch target computed.
//   EXEC: ALU op; beq: if A==B pc<=pc+1+imm else pc+1, retire, ->FETCH;
//    j: pc<=tgt mod IMEM_DEPTH, retire, ->FETCH; halt: retire, ->HALT (pc unchanged).
//   MEM: lw reads DMEM->MDR ->WB; sw writes DMEM, pc+1, retire ->FETCH.
//   WB: write rd (R) or rt (addi/lw), pc+1, retire, ->FETCH.
//  Cycles per instr: R/addi 4, lw 5, sw 4, beq 3, j 3, halt 3.
//  pc wraps modulo IMEM_DEPTH (pc+1 and pc+1+imm alike).
//  Register write and DECODE read never overlap (multi-cycle), so no forwarding.
//  prog_we while busy: ignored, ROM unchanged. Same-cycle start and prog_we in IDLE: both take effect;
//   the FETCH of the new program occurs the following cycle and sees the written word.
//  Reset mid-instruction: aborts immediately, no partial register/DMEM write survives.
// TESTING
//  1 Load addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; halt; start -> dbg r3=2, halted=1,
//    4 retire pulses, halt reached 15 cycles after start.
//  2 sw r1,4(r0) then lw r4,4(r0) with r1=0x1234 -> r4=0x1234; lw 5 cycles, sw 4 cycles.
//  3 Loop: r1=3; beq r1,r0,+2; addi r1,r1,-1; j 1; halt -> r1=0 on halt, pc=4.
//  4 Opcode 0x3E at ROM[0] -> err=1, halted=1, no register changed; next start clears err.
//  5 Assert reset low during WB of add r5 -> r5=0, state IDLE, busy=0 asynchronously.
//  6 DATA_W=16, REG_COUNT=4, IMEM_DEPTH=8: j 7, then pc+1 wraps to 0; addi r1,r0,0x7FFF
//    then addi r1,r1,1 -> r1=0x8000; slt r2,r1,r0 -> r2=1.

Source files
------------

// File: rtl/multicycle_datapath_if.sv
// multicycle_datapath_if: program-load, launch, debug-peek and status bus of multicycle_datapath
//   master drives start/prog_we/prog_addr/prog_data/dbg_addr; slave returns dbg_data/pc/busy/halted/err/retire
interface multicycle_datapath_if #(
    parameter int DATA_W     = 32,
    parameter int REG_COUNT  = 8,
    parameter int IMEM_DEPTH = 16
);
    logic                          start;
    logic                          prog_we;
    logic [$clog2(IMEM_DEPTH)-1:0] prog_addr;
    logic [31:0]                   prog_data;
    logic [$clog2(REG_COUNT)-1:0]  dbg_addr;
    logic [DATA_W-1:0]             dbg_data;
    logic [$clog2(IMEM_DEPTH)-1:0] pc;
    logic                          busy;
    logic                          halted;
    logic                          err;
    logic                          retire;

    modport master (
        output start, prog_we, prog_addr, prog_data, dbg_addr,
        input  dbg_data, pc, busy, halted, err, retire
    );
    modport slave (
        input  start, prog_we, prog_addr, prog_data, dbg_addr,
        output dbg_data, pc, busy, halted, err, retire
    );
endinterface

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multi-cycle MIPS-subset core (fetch/decode/exec/mem/wb) over one shared ALU
//   clk, reset (async, active-low), bus (slave): ROM load + start, register debug read, pc/busy/halted/err/retire
module multicycle_datapath #(
    parameter int DATA_W     = 32,
    parameter int REG_COUNT  = 8,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_datapath_if.slave bus
);
    localparam int RW = $clog2(REG_COUNT);
    localparam int PW = $clog2(IMEM_DEPTH);
    localparam int MW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t            state_q;
    logic [31:0]       rom_q [IMEM_DEPTH];
    logic [DATA_W-1:0] reg_q [REG_COUNT];
    logic [DATA_W-1:0] mem_q [DMEM_DEPTH];
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
    logic [PW-1:0]     pc_q, br_q;
    logic              busy_q, halted_q, err_q, retire_q;

    logic [5:0]        op, fn;
    logic [4:0]        sh;
    logic [RW-1:0]     rs, rt, rd, wr_idx;
    logic [DATA_W-1:0] imm_x, alu_d, wr_val;
    logic [PW-1:0]     pc_inc;
    logic [MW-1:0]     maddr;
    logic              fn_ok, idle_like;
    logic              unused_ir;

    assign op        = ir_q[31:26];
    assign fn        = ir_q[5:0];
    assign sh        = ir_q[10:6];
    assign rs        = ir_q[21 +: RW];
    assign rt        = ir_q[16 +: RW];
    assign rd        = ir_q[11 +: RW];
    assign imm_x     = DATA_W'($signed(ir_q[15:0]));
    assign unused_ir = ^ir_q[25:0];
    assign pc_inc    = pc_q + PW'(1);
    assign maddr     = alu_q[MW-1:0];
    assign wr_idx    = op == OP_R ? rd : rt;
    assign wr_val    = op == OP_LW ? mdr_q : alu_q;
    assign idle_like = state_q == IDLE || state_q == HALT;
    assign fn_ok     = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL};

    // Single ALU: address/immediate adds for every non-R opcode, funct-selected op otherwise
    assign alu_d = op != OP_R   ? a_q + imm_x :
                   fn == FN_ADD ? a_q + b_q :
                   fn == FN_SUB ? a_q - b_q :
                   fn == FN_AND ? a_q & b_q :
                   fn == FN_OR  ? a_q | b_q :
                   fn == FN_SLT ? DATA_W'($signed(a_q) < $signed(b_q)) :
                   fn == FN_SLL ? b_q << sh : '0;

    assign bus.dbg_data = bus.dbg_addr == '0 ? '0 : reg_q[bus.dbg_addr];
    assign bus.pc       = pc_q;
    assign bus.busy     = busy_q;
    assign bus.halted   = halted_q;
    assign bus.err      = err_q;
    assign bus.retire   = retire_q;

    // Program ROM has no reset so a loaded program survives reset
    always_ff @(posedge clk) begin
        if (bus.prog_we && idle_like) rom_q[bus.prog_addr] <= bus.prog_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            br_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            retire_q <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) reg_q[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                IDLE, HALT: begin
                    if (bus.start) begin
                        pc_q     <= '0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                        state_q  <= FETCH;
                    end
                end
                FETCH: begin
                    ir_q    <= rom_q[pc_q];
                    state_q <= DECODE;
                end
                DECODE: begin
                    a_q     <= reg_q[rs];
                    b_q     <= reg_q[rt];
                    br_q    <= pc_inc + ir_q[PW-1:0];
                    state_q <= EXEC;
                end
                EXEC: begin
                    alu_q <= alu_d;
                    if (op == OP_BEQ || op == OP_J || op == OP_HALT) retire_q <= 1'b1;
                    if (op == OP_BEQ) pc_q <= a_q == b_q ? br_q : pc_inc;
                    if (op == OP_J) pc_q <= ir_q[PW-1:0];
                    if ((op == OP_R && fn_ok) || op == OP_ADDI) state_q <= WB;
                    else if (op == OP_LW || op == OP_SW) state_q <= MEM;
                    else if (op == OP_BEQ || op == OP_J) state_q <= FETCH;
                    else begin
                        // halt, or an unknown opcode/funct that stops the core with err set
                        state_q  <= HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        err_q    <= op != OP_HALT;
                    end
                end
                MEM: begin
                    if (op == OP_LW) begin
                        mdr_q   <= mem_q[maddr];
                        state_q <= WB;
                    end else begin
                        mem_q[maddr] <= b_q;
                        pc_q         <= pc_inc;
                        retire_q     <= 1'b1;
                        state_q      <= FETCH;
                    end
                end
                WB: begin
                    if (wr_idx != '0) reg_q[wr_idx] <= wr_val;
                    pc_q     <= pc_inc;
                    retire_q <= 1'b1;
                    state_q  <= FETCH;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed and randomized checks of multicycle_datapath against an ISA-level model
module tb_multicycle_datapath;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_datapath_if d ();
    multicycle_datapath_if #(.DATA_W(16), .REG_COUNT(4), .IMEM_DEPTH(8)) s ();

    multicycle_datapath u_dut (.clk(clk), .reset(rst_n), .bus(d));
    multicycle_datapath #(.DATA_W(16), .REG_COUNT(4), .IMEM_DEPTH(8), .DMEM_DEPTH(8))
        u_small (.clk(clk), .reset(rst_n), .bus(s));

    localparam logic [31:0] HALT_I = 32'hFC00_0000;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] prog [16];
    logic [31:0] m_reg [8];
    logic [31:0] m_mem [8];
    int          m_cyc [$];
    int          m_pc;
    bit          m_err;
    int          d_cyc [$];
    int          d_total;

    function automatic logic [31:0] enc_r(int rd, int rs, int rt, int fn, int sh = 0);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(int op, int rt, int rs, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(int t);
        return {6'd2, 26'(t)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = '0;
            m_mem[i] = '0;
        end
    endtask

    // Instruction-set simulator: executes prog from pc 0, recording cycles per retired instruction
    task automatic model_run();
        int pc;
        bit done;
        int rs, rt, rd;
        logic [31:0] ir, a, b, imm, r, ad;
        pc = 0;
        done = 0;
        m_err = 0;
        m_cyc.delete();
        for (int n = 0; n < 1000 && !done; n++) begin
            ir = prog[pc];
            rs = int'(ir[23:21]);
            rt = int'(ir[18:16]);
            rd = int'(ir[13:11]);
            a = m_reg[rs];
            b = m_reg[rt];
            imm = {{16{ir[15]}}, ir[15:0]};
            ad = a + imm;
            r = '0;
            case (ir[31:26])
                6'h00: begin
                    case (ir[5:0])
                        6'h20: r = a + b;
                        6'h22: r = a - b;
                        6'h24: r = a & b;
                        6'h25: r = a | b;
                        6'h2A: r = $signed(a) < $signed(b) ? 32'd1 : 32'd0;
                        6'h00: r = b << ir[10:6];
                        default: begin
                            m_err = 1;
                            done = 1;
                        end
                    endcase
                    if (!done) begin
                        if (rd != 0) m_reg[rd] = r;
                        m_cyc.push_back(4);
                        pc = (pc + 1) % 16;
                    end
                end
                6'h08: begin
                    if (rt != 0) m_reg[rt] = ad;
                    m_cyc.push_back(4);
                    pc = (pc + 1) % 16;
                end
                6'h23: begin
                    if (rt != 0) m_reg[rt] = m_mem[ad[2:0]];
                    m_cyc.push_back(5);
                    pc = (pc + 1) % 16;
                end
                6'h2B: begin
                    m_mem[ad[2:0]] = b;
                    m_cyc.push_back(4);
                    pc = (pc + 1) % 16;
                end
                6'h04: begin
                    pc = a == b ? (pc + 1 + int'(imm)) & 15 : (pc + 1) % 16;
                    m_cyc.push_back(3);
                end
                6'h02: begin
                    pc = int'(ir[25:0]) & 15;
                    m_cyc.push_back(3);
                end
                6'h3F: begin
                    m_cyc.push_back(3);
                    done = 1;
                end
                default: begin
                    m_err = 1;
                    done = 1;
                end
            endcase
        end
        m_pc = pc;
    endtask

    task automatic load_main();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            d.prog_we = 1'b1;
            d.prog_addr = 4'(i);
            d.prog_data = prog[i];
        end
        @(negedge clk);
        d.prog_we = 1'b0;
    endtask

    // Starts the main core and records retire spacing until halted (bounded)
    task automatic run_main();
        int last;
        last = 0;
        d_cyc.delete();
        d_total = -1;
        @(negedge clk);
        d.start = 1'b1;
        @(posedge clk);
        #1 d.start = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge clk);
            #1;
            if (d.retire) begin
                d_cyc.push_back(c - last);
                last = c;
            end
            if (d.halted) begin
                d_total = c;
                break;
            end
        end
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 16; i++) prog[i] = HALT_I;
    endtask

    task automatic test_reset();
        d.start = 0; d.prog_we = 0; d.prog_addr = 0; d.prog_data = 0; d.dbg_addr = 0;
        s.start = 0; s.prog_we = 0; s.prog_addr = 0; s.prog_data = 0; s.dbg_addr = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        n_chk++;
        if ({d.busy, d.halted, d.err, d.retire} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {d.busy, d.halted, d.err, d.retire});
        end
        n_chk++;
        if (d.pc !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_pc: got %0d want 0", d.pc);
        end
        for (int i = 0; i < 8; i++) begin
            d.dbg_addr = 3'(i);
            #1;
            n_chk++;
            if (d.dbg_data !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_reg r%0d: got %0h want 0", i, d.dbg_data);
            end
        end
    endtask

    task automatic test_small();
        logic [31:0] sp [8];
        int cyc, ret;
        sp[0] = enc_i(4, 0, 3, 1);
        sp[1] = HALT_I;
        sp[2] = enc_i(8, 1, 0, 16'h7FFF);
        sp[3] = enc_i(8, 1, 1, 1);
        sp[4] = enc_r(2, 1, 0, 42);
        sp[5] = enc_j(15);
        sp[6] = HALT_I;
        sp[7] = enc_i(8, 3, 0, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s.prog_we = 1'b1;
            s.prog_addr = 3'(i);
            s.prog_data = sp[i];
        end
        @(negedge clk);
        s.prog_we = 1'b0;
        s.start = 1'b1;
        @(posedge clk);
        #1 s.start = 1'b0;
        cyc = 0;
        ret = 0;
        while (!s.halted && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (s.retire) ret++;
        end
        n_chk++;
        if (cyc !== 28 || !s.halted) begin
            n_fail++;
            $display("FAIL small_cycles: got %0d (halted %b) want 28", cyc, s.halted);
        end
        n_chk++;
        if (ret !== 8) begin
            n_fail++;
            $display("FAIL small_retires: got %0d want 8", ret);
        end
        n_chk++;
        if (s.pc !== 3'd1) begin
            n_fail++;
            $display("FAIL small_pc_wrap: got %0d want 1", s.pc);
        end
        s.dbg_addr = 2'd1;
        #1;
        n_chk++;
        if (s.dbg_data !== 16'h8000) begin
            n_fail++;
            $display("FAIL small_r1: got %0h want 8000", s.dbg_data);
        end
        s.dbg_addr = 2'd2;
        #1;
        n_chk++;
        if (s.dbg_data !== 16'h0001) begin
            n_fail++;
            $display("FAIL small_slt_r2: got %0h want 1", s.dbg_data);
        end
        s.dbg_addr = 2'd3;
        #1;
        n_chk++;
        if (s.dbg_data !== 16'h0001) begin
            n_fail++;
            $display("FAIL small_r3: got %0h want 1", s.dbg_data);
        end
    endtask

    task automatic test_arith();
        fill_halt();
        prog[0] = enc_i(8, 1, 0, 5);
        prog[1] = enc_i(8, 2, 0, -3);
        prog[2] = enc_r(3, 1, 2, 32);
        load_main();
        model_run();
        run_main();
        d.dbg_addr = 3'd3;
        #1;
        n_chk++;
        if (d.dbg_data !== 32'd2) begin
            n_fail++;
            $display("FAIL arith_r3: got %0h want 2", d.dbg_data);
        end
        n_chk++;
        if (d_total !== 15 || d.halted !== 1'b1) begin
            n_fail++;
            $display("FAIL arith_halt_cycles: got %0d (halted %b) want 15", d_total, d.halted);
        end
        n_chk++;
        if (d_cyc.size() !== 4) begin
            n_fail++;
            $display("FAIL arith_retires: got %0d want 4", d_cyc.size());
        end
        n_chk++;
        if (d.busy !== 1'b0 || d.err !== 1'b0) begin
            n_fail++;
            $display("FAIL arith_busy_err: got %b%b want 00", d.busy, d.err);
        end
    endtask

    task automatic test_mem();
        fill_halt();
        prog[0] = enc_i(8, 1, 0, 16'h1234);
        prog[1] = enc_i(43, 1, 0, 4);
        prog[2] = enc_i(35, 4, 0, 4);
        load_main();
        model_run();
        run_main();
        d.dbg_addr = 3'd4;
        #1;
        n_chk++;
        if (d.dbg_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL mem_r4: got %0h want 1234", d.dbg_data);
        end
        n_chk++;
        if (d_cyc.size() !== 4) begin
            n_fail++;
            $display("FAIL mem_retires: got %0d want 4", d_cyc.size());
        end else begin
            n_chk++;
            if (d_cyc[1] !== 4 || d_cyc[2] !== 5) begin
                n_fail++;
                $display("FAIL mem_sw_lw_cycles: got %0d/%0d want 4/5", d_cyc[1], d_cyc[2]);
            end
        end
    endtask

    task automatic test_loop();
        fill_halt();
        prog[0] = enc_i(8, 1, 0, 3);
        prog[1] = enc_i(4, 0, 1, 2);
        prog[2] = enc_i(8, 1, 1, -1);
        prog[3] = enc_j(1);
        load_main();
        model_run();
        run_main();
        d.dbg_addr = 3'd1;
        #1;
        n_chk++;
        if (d.dbg_data !== 32'd0) begin
            n_fail++;
            $display("FAIL loop_r1: got %0h want 0", d.dbg_data);
        end
        n_chk++;
        if (d.pc !== 4'd4) begin
            n_fail++;
            $display("FAIL loop_pc: got %0d want 4", d.pc);
        end
        n_chk++;
        if (d_total !== 40) begin
            n_fail++;
            $display("FAIL loop_cycles: got %0d want 40", d_total);
        end
    endtask

    task automatic test_err();
        fill_halt();
        prog[0] = 32'hF800_0000;
        load_main();
        model_run();
        run_main();
        n_chk++;
        if ({d.err, d.halted, d.busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL err_opcode_flags: got %b want 110", {d.err, d.halted, d.busy});
        end
        n_chk++;
        if (d_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL err_no_retire: got %0d want 0", d_cyc.size());
        end
        prog[0] = enc_r(3, 1, 2, 6'h3F);
        load_main();
        model_run();
        run_main();
        n_chk++;
        if (d.err !== 1'b1 || d.halted !== 1'b1) begin
            n_fail++;
            $display("FAIL err_funct_flags: got %b%b want 11", d.err, d.halted);
        end
        for (int i = 0; i < 8; i++) begin
            d.dbg_addr = 3'(i);
            #1;
            n_chk++;
            if (d.dbg_data !== m_reg[i]) begin
                n_fail++;
                $display("FAIL err_regs_kept r%0d: got %0h want %0h", i, d.dbg_data, m_reg[i]);
            end
        end
        prog[0] = HALT_I;
        load_main();
        model_run();
        run_main();
        n_chk++;
        if (d.err !== 1'b0 || d.halted !== 1'b1) begin
            n_fail++;
            $display("FAIL err_cleared_by_start: got err %b halted %b want 0 1", d.err, d.halted);
        end
    endtask

    task automatic test_prog_lock();
        int c;
        fill_halt();
        prog[0] = enc_i(8, 6, 0, 11);
        load_main();
        model_run();
        @(negedge clk);
        d.start = 1'b1;
        @(posedge clk);
        #1 d.start = 1'b0;
        @(negedge clk);
        d.prog_we = 1'b1;
        d.prog_addr = 4'd0;
        d.prog_data = enc_i(8, 6, 0, 99);
        @(negedge clk);
        d.prog_we = 1'b0;
        c = 0;
        while (!d.halted && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_chk++;
        if (!d.halted) begin
            n_fail++;
            $display("FAIL lock_timeout: got halted %b want 1", d.halted);
        end
        model_run();
        run_main();
        d.dbg_addr = 3'd6;
        #1;
        n_chk++;
        if (d.dbg_data !== 32'd11) begin
            n_fail++;
            $display("FAIL lock_rom_unchanged r6: got %0d want 11", d.dbg_data);
        end
    endtask

    task automatic test_start_prog();
        int c;
        prog[0] = enc_i(8, 6, 0, 55);
        model_run();
        @(negedge clk);
        d.start = 1'b1;
        d.prog_we = 1'b1;
        d.prog_addr = 4'd0;
        d.prog_data = prog[0];
        @(posedge clk);
        #1;
        d.start = 1'b0;
        d.prog_we = 1'b0;
        c = 0;
        while (!d.halted && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        d.dbg_addr = 3'd6;
        #1;
        n_chk++;
        if (d.dbg_data !== 32'd55 || !d.halted) begin
            n_fail++;
            $display("FAIL start_with_write r6: got %0d (halted %b) want 55", d.dbg_data, d.halted);
        end
    endtask

    task automatic test_random();
        int fns [6];
        int k, tot;
        fns = '{32, 34, 36, 37, 42, 0};
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 15; i++) begin
                k = $urandom_range(0, 3);
                case (k)
                    0: prog[i] = enc_i(8, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
                    1: prog[i] = enc_r($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                                       fns[$urandom_range(0, 5)], $urandom_range(0, 31));
                    2: prog[i] = enc_i(35, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
                    default: prog[i] = enc_i(43, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
                endcase
            end
            prog[15] = HALT_I;
            load_main();
            model_run();
            run_main();
            tot = 0;
            foreach (m_cyc[i]) tot += m_cyc[i];
            n_chk++;
            if (d_total !== tot) begin
                n_fail++;
                $display("FAIL rand%0d_total_cycles: got %0d want %0d", it, d_total, tot);
            end
            n_chk++;
            if (d_cyc != m_cyc) begin
                n_fail++;
                $display("FAIL rand%0d_cycle_profile: got %0d retires want %0d", it, d_cyc.size(), m_cyc.size());
            end
            n_chk++;
            if (d.pc !== 4'(m_pc) || d.err !== m_err) begin
                n_fail++;
                $display("FAIL rand%0d_pc_err: got %0d/%b want %0d/%b", it, d.pc, d.err, m_pc, m_err);
            end
            for (int i = 0; i < 8; i++) begin
                d.dbg_addr = 3'(i);
                #1;
                n_chk++;
                if (d.dbg_data !== m_reg[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_reg r%0d: got %0h want %0h", it, i, d.dbg_data, m_reg[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_halt();
        prog[0] = enc_i(8, 1, 0, 7);
        prog[1] = enc_i(8, 2, 0, 9);
        prog[2] = enc_r(5, 1, 2, 32);
        load_main();
        @(negedge clk);
        d.start = 1'b1;
        @(posedge clk);
        #1 d.start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        n_chk++;
        if (d.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy_before: got %b want 1", d.busy);
        end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({d.busy, d.halted, d.retire} !== 3'b000 || d.pc !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_async_idle: got %b pc %0d want 000 pc 0", {d.busy, d.halted, d.retire}, d.pc);
        end
        d.dbg_addr = 3'd5;
        #1;
        n_chk++;
        if (d.dbg_data !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_r5: got %0h want 0", d.dbg_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (d.busy !== 1'b0 || d.dbg_data !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_after_release: got busy %b r5 %0h want 0 0", d.busy, d.dbg_data);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_small();
        test_arith();
        test_mem();
        test_loop();
        test_err();
        test_prog_lock();
        test_start_prog();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
